// File: rtl/wisc_pkg.sv
// Shared WISC-SP20 definitions: opcodes, immediate-extension encodings,
// decode-buffer state encoding and the buffered entry layout.
package wisc_pkg;

   localparam int N = 16;

   // Opcode field is inst[15:11]
   localparam logic [4:0] OP_HALT  = 5'b00000;
   localparam logic [4:0] OP_J     = 5'b00100;
   localparam logic [4:0] OP_JR    = 5'b00101;
   localparam logic [4:0] OP_JAL   = 5'b00110;
   localparam logic [4:0] OP_JALR  = 5'b00111;
   localparam logic [4:0] OP_ADDI  = 5'b01000;
   localparam logic [4:0] OP_SUBI  = 5'b01001;
   localparam logic [4:0] OP_XORI  = 5'b01010;
   localparam logic [4:0] OP_ANDNI = 5'b01011;
   localparam logic [4:0] OP_BEQZ  = 5'b01100;
   localparam logic [4:0] OP_BNEZ  = 5'b01101;
   localparam logic [4:0] OP_BLTZ  = 5'b01110;
   localparam logic [4:0] OP_BGEZ  = 5'b01111;
   localparam logic [4:0] OP_ST    = 5'b10000;
   localparam logic [4:0] OP_LD    = 5'b10001;
   localparam logic [4:0] OP_SLBI  = 5'b10010;
   localparam logic [4:0] OP_STU   = 5'b10011;
   localparam logic [4:0] OP_ROLI  = 5'b10100;
   localparam logic [4:0] OP_SLLI  = 5'b10101;
   localparam logic [4:0] OP_RORI  = 5'b10110;
   localparam logic [4:0] OP_SRLI  = 5'b10111;
   localparam logic [4:0] OP_LBI   = 5'b11000;

   // Immediate field-size selects for the downstream extender
   localparam logic [1:0] SM_IMM  = 2'b00;
   localparam logic [1:0] LG_IMM  = 2'b01;
   localparam logic [1:0] DIS_IMM = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN       = 2'b00,
      ST_HALT_PEND = 2'b01,
      ST_HALTED    = 2'b10
   } state_t;

   // One buffered instruction together with its decode result
   typedef struct packed {
      logic [N-1:0] inst;
      logic [N-1:0] pc;
      logic         ext_sign;
      logic [1:0]   ext_op;
      logic         imm_used;
      logic         halt;
   } buf_entry_t;

endpackage

// File: rtl/inst_decode_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the decode buffer.
// master = the environment driving fetch and consuming decode, slave = the buffer.
interface inst_decode_buffer_if;

   logic                   in_valid;
   logic                   in_ready;
   logic [wisc_pkg::N-1:0] in_inst;
   logic [wisc_pkg::N-1:0] in_pc;
   logic                   flush;
   logic                   out_valid;
   logic                   out_ready;
   logic [wisc_pkg::N-1:0] out_inst;
   logic [wisc_pkg::N-1:0] out_pc;
   logic                   out_ext_sign;
   logic [1:0]             out_ext_op;
   logic                   out_imm_used;
   logic                   out_halt;
   logic                   halted;

   modport master (
      output in_valid, in_inst, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_inst, out_pc, out_ext_sign,
             out_ext_op, out_imm_used, out_halt, halted
   );

   modport slave (
      input  in_valid, in_inst, in_pc, flush, out_ready,
      output in_ready, out_valid, out_inst, out_pc, out_ext_sign,
             out_ext_op, out_imm_used, out_halt, halted
   );

endinterface

// File: rtl/ext_ctrl_decode.sv
// Combinational opcode decoder producing the immediate-extension controls
// and the HALT flag for one instruction.
module ext_ctrl_decode
   import wisc_pkg::*;
(
   input  logic [4:0] opcode,
   output logic       ext_sign,
   output logic [1:0] ext_op,
   output logic       imm_used,
   output logic       is_halt
);

   // Table lookup: opcodes without an immediate fall through to all-zero controls
   always_comb begin
      ext_sign = 1'b0;
      ext_op   = SM_IMM;
      imm_used = 1'b0;
      is_halt  = (opcode == OP_HALT);
      case (opcode)
         OP_ADDI, OP_SUBI, OP_ST, OP_LD, OP_STU: begin
            ext_sign = 1'b1;
            ext_op   = SM_IMM;
            imm_used = 1'b1;
         end
         OP_XORI, OP_ANDNI, OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
            ext_sign = 1'b0;
            ext_op   = SM_IMM;
            imm_used = 1'b1;
         end
         OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ, OP_LBI, OP_JR, OP_JALR: begin
            ext_sign = 1'b1;
            ext_op   = LG_IMM;
            imm_used = 1'b1;
         end
         OP_SLBI: begin
            ext_sign = 1'b0;
            ext_op   = LG_IMM;
            imm_used = 1'b1;
         end
         OP_J, OP_JAL: begin
            ext_sign = 1'b1;
            ext_op   = DIS_IMM;
            imm_used = 1'b1;
         end
         default: begin
            ext_sign = 1'b0;
            ext_op   = SM_IMM;
            imm_used = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/inst_decode_buffer.sv
// Decode-stage front end: two-entry skid buffer (OUT + SKID) holding
// pre-decoded instructions, plus the HALT drain-and-stop state machine.
// Decode is done once on the input path so every output is a register.
module inst_decode_buffer
   import wisc_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   inst_decode_buffer_if.slave  bus
);

   state_t     state;
   buf_entry_t out_q;
   buf_entry_t skid_q;
   buf_entry_t new_entry;
   logic       out_v;
   logic       skid_v;
   logic       dec_sign;
   logic [1:0] dec_op;
   logic       dec_imm;
   logic       dec_halt;
   logic       accept;
   logic       drain;

   ext_ctrl_decode u_ext_ctrl_decode (
      .opcode   (bus.in_inst[15:11]),
      .ext_sign (dec_sign),
      .ext_op   (dec_op),
      .imm_used (dec_imm),
      .is_halt  (dec_halt)
   );

   // Bundle the incoming word with its decode so it travels as one entry
   always_comb begin
      new_entry          = '0;
      new_entry.inst     = bus.in_inst;
      new_entry.pc       = bus.in_pc;
      new_entry.ext_sign = dec_sign;
      new_entry.ext_op   = dec_op;
      new_entry.imm_used = dec_imm;
      new_entry.halt     = dec_halt;
   end

   // Ready comes only from registered state and flush, never from in_valid
   assign bus.in_ready = !skid_v && (state == ST_RUN) && !bus.flush;
   assign accept       = bus.in_valid && bus.in_ready;
   assign drain        = out_v && bus.out_ready;

   assign bus.out_valid    = out_v;
   assign bus.out_inst     = out_q.inst;
   assign bus.out_pc       = out_q.pc;
   assign bus.out_ext_sign = out_q.ext_sign;
   assign bus.out_ext_op   = out_q.ext_op;
   assign bus.out_imm_used = out_q.imm_used;
   assign bus.out_halt     = out_q.halt;
   assign bus.halted       = (state == ST_HALTED);

   // Skid buffer: SKID refills OUT on drain; new entries take OUT when it is free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_v  <= 1'b0;
         skid_v <= 1'b0;
         out_q  <= '0;
         skid_q <= '0;
      end else if (bus.flush && (state != ST_HALTED)) begin
         out_v  <= 1'b0;
         skid_v <= 1'b0;
      end else if (drain) begin
         if (skid_v) begin
            out_q  <= skid_q;
            skid_v <= 1'b0;
         end else if (accept) begin
            out_q <= new_entry;
         end else begin
            out_v <= 1'b0;
         end
      end else if (accept) begin
         if (!out_v) begin
            out_q <= new_entry;
            out_v <= 1'b1;
         end else begin
            skid_q <= new_entry;
            skid_v <= 1'b1;
         end
      end
   end

   // HALT sequencing: stop accepting after HALT, stop entirely once it retires
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         case (state)
            ST_RUN: begin
               if (accept && new_entry.halt) begin
                  state <= ST_HALT_PEND;
               end
            end
            ST_HALT_PEND: begin
               if (bus.flush) begin
                  state <= ST_RUN;
               end else if (drain && out_q.halt) begin
                  state <= ST_HALTED;
               end
            end
            ST_HALTED: begin
               state <= ST_HALTED;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

endmodule

// File: doc/inst_decode_buffer.md
# inst_decode_buffer

Decode-stage front end of the WISC-SP20 pipeline. Accepts 16-bit instructions from fetch over a valid/ready handshake and buffers them in a two-entry skid buffer. Decodes each opcode into the immediate-extension controls (sign select and field-size select) plus a few stage flags. Presents the result, registered, to the downstream extender/decode logic. Also owns the HALT drain-and-stop sequence.

## Interface
- N, 16, instruction and PC width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  buffer can accept this cycle
- in_inst  in  N  instruction word; opcode is in_inst[15:11]
- in_pc  in  N  PC of in_inst
- flush  in  1  discard all buffered and incoming instructions
- out_valid  out  1  decoded entry available
- out_ready  in  1  downstream consumes this cycle
- out_inst  out  N  buffered instruction
- out_pc  out  N  buffered PC
- out_ext_sign  out  1  1 = sign-extend, 0 = zero-extend
- out_ext_op  out  2  00 = 5-bit imm [4:0], 01 = 8-bit imm [7:0], 10 = 11-bit displacement [10:0]
- out_imm_used  out  1  instruction carries an immediate
- out_halt  out  1  entry is HALT
- halted  out  1  block has stopped after HALT retired

## Operation
- Decode table, keyed on opcode, as {sign, ext_op, imm_used}:
  - ADDI 01000, SUBI 01001, ST 10000, LD 10001, STU 10011: {1,00,1}
  - XORI 01010, ANDNI 01011, ROLI 10100, SLLI 10101, RORI 10110, SRLI 10111: {0,00,1}
  - BEQZ 01100, BNEZ 01101, BLTZ 01110, BGEZ 01111, LBI 11000, JR 00101, JALR 00111: {1,01,1}
  - SLBI 10010: {0,01,1}
  - J 00100, JAL 00110: {1,10,1}
  - All other opcodes: {0,00,0}
- HALT is opcode 00000. out_halt is set only for opcode 00000.
- Decoding happens at accept time. The result is stored with the entry, so outputs come only from registers.
- Buffer has two entries: an output register (OUT) and a skid register (SKID).
  - Accept occurs when in_valid && in_ready. The entry goes to OUT if OUT is empty or draining this cycle; otherwise it goes to SKID.
  - When OUT drains, SKID moves to OUT in the same cycle.
  - Order is strictly FIFO. No entry is ever dropped except by flush.
- in_ready = !SKID_valid && state==RUN. in_ready is registered-derived and never depends combinationally on in_valid.
- State machine:
  - RUN: normal operation. Accepting a HALT moves to HALT_PEND.
  - HALT_PEND: in_ready=0. When the HALT entry drains from OUT (out_valid && out_ready && out_halt), move to HALTED.
  - HALTED: in_ready=0, out_valid=0, halted=1. Only rst leaves this state.
- flush:
  - Clears OUT and SKID in the same cycle. An input offered in that cycle is not accepted, and in_ready is forced to 0.
  - In HALT_PEND, flush returns the state to RUN, because the HALT was speculative.
  - In HALTED, flush has no effect.
- Simultaneous drain and accept with SKID empty: the new entry lands in OUT, and occupancy stays at 1.

## Timing
- Reset values:
  - state=RUN
  - OUT and SKID invalid
  - out_valid=0, in_ready=1, halted=0
  - out_inst=0, out_pc=0, out_ext_sign=0, out_ext_op=00, out_imm_used=0, out_halt=0
- Latency: an instruction accepted in cycle t is visible on out_* in cycle t+1.
- Throughput: one instruction per cycle while out_ready=1.
- Once out_valid=1, the out_* signals hold stable until consumed or flushed.
- Reset asserted mid-operation returns the block to reset values immediately (asynchronously). Any in-flight entries are lost.

## Structure
- The shared package wisc_pkg holds:
  - the 5-bit opcode constants
  - the ext_op encodings SM_IMM=2'b00, LG_IMM=2'b01, DIS_IMM=2'b10
  - the state encoding
- One combinational sub-module, ext_ctrl_decode: opcode in; ext_sign, ext_op, imm_used, is_halt out. It is instantiated once, on the input path.
- The buffer and FSM live in inst_decode_buffer.

## Test plan
- Decode sweep:
  - Feed 16'h4005 (ADDI) -> sign=1, op=00, imm_used=1.
  - Feed 16'h5000 (XORI) -> sign=0, op=00.
  - Feed 16'hC0FF (LBI) -> sign=1, op=01.
  - Feed 16'h9012 (SLBI) -> sign=0, op=01.
  - Feed 16'h2000 (J) -> sign=1, op=10.
  - Feed 16'hD800 (R-format) -> imm_used=0.
  - Each result must appear one cycle after accept.
- Backpressure: hold out_ready=0 while offering 3 instructions. Required: 2 accepted, then in_ready=0. Release out_ready; required: they emerge in order with no loss or duplication.
- Streaming: 8 back-to-back instructions with out_ready=1 -> in_ready stays 1 and 8 outputs appear on 8 consecutive cycles.
- Flush with both entries full and in_valid=1: required next cycle out_valid=0 and nothing accepted. The first post-flush input emerges one cycle after accept.
- HALT, normal case: stream ADDI, 16'h0000, ADDI. Required: the trailing ADDI is not accepted, halted=1 the cycle after HALT drains, and the block stays halted.
- HALT, flushed: flush during HALT_PEND -> state returns to RUN and in_ready=1 next cycle.
- Reset: assert rst mid-stream -> all outputs return to reset values without waiting for a clock edge.
